// File: rtl/seeg_miso_deskew.sv
// MISO capture stage: per-line programmable sample delay, MSB-first word deserialisation
// and a single-register valid/ready output beat carrying all lines' words.
module seeg_miso_deskew #(
  parameter int unsigned N_LINES   = 8,
  parameter int unsigned DELAY_W   = 4,
  parameter int unsigned MAX_DELAY = 7,
  parameter int unsigned WORD_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_delay_wr,
  input  logic [N_LINES*DELAY_W-1:0]     cfg_delay_data,
  output logic [N_LINES*DELAY_W-1:0]     cfg_delay_q,
  input  logic                           frame_start,
  input  logic                           sample_stb,
  input  logic [N_LINES-1:0]             miso,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [N_LINES*WORD_BITS-1:0]   m_data,
  output logic                           overflow,
  input  logic                           clr_overflow,
  output logic                           busy
);

  localparam int unsigned CntW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_BITS - 1);
  localparam logic [DELAY_W-1:0] DelayMax = DELAY_W'(MAX_DELAY);
  localparam logic [MAX_DELAY:0] StbEarlyMask = {1'b0, {MAX_DELAY{1'b1}}};

  logic [N_LINES*DELAY_W-1:0]   pend_q, pend_d;
  logic [N_LINES*DELAY_W-1:0]   act_q, act_d;
  logic [N_LINES-1:0]           miso_r_q;
  logic [MAX_DELAY:0]           stb_p_q, stb_p_d;
  logic [N_LINES*WORD_BITS-1:0] sh_q, sh_d, sh_cap;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         valid_q, valid_d;
  logic [N_LINES*WORD_BITS-1:0] data_q, data_d;
  logic                         ovf_q, ovf_d;
  logic [N_LINES-1:0]           cap;
  logic                         adv, complete;

  // Per-line strobe tap, selected by the clamped active delay.
  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
    logic [DELAY_W-1:0] dly_raw, dly;
    logic               cap_l;
    assign dly_raw = act_q[gi*DELAY_W +: DELAY_W];
    assign dly     = (dly_raw > DelayMax) ? DelayMax : dly_raw;
    always_comb begin
      cap_l = 1'b0;
      for (int unsigned k = 0; k <= MAX_DELAY; k++) begin
        if (dly == DELAY_W'(k)) cap_l = stb_p_q[k];
      end
    end
    assign cap[gi] = cap_l;
  end

  always_comb begin
    pend_d = cfg_delay_wr ? cfg_delay_data : pend_q;
    act_d  = frame_start ? pend_d : act_q;

    stb_p_d[0] = sample_stb;
    for (int unsigned k = 1; k <= MAX_DELAY; k++) stb_p_d[k] = stb_p_q[k-1];

    sh_cap = sh_q;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (cap[i]) begin
        sh_cap[i*WORD_BITS +: WORD_BITS] = {sh_q[i*WORD_BITS +: WORD_BITS-1], miso_r_q[i]};
      end
    end
    sh_d = sh_cap;

    // By the last pipeline stage every line has captured its bit.
    adv      = stb_p_q[MAX_DELAY];
    complete = adv && (cnt_q == CntLast);
    cnt_d    = cnt_q;
    if (adv) cnt_d = complete ? '0 : cnt_q + 1'b1;

    if (frame_start) begin
      cnt_d   = '0;
      sh_d    = '0;
      stb_p_d = '0;
    end

    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (complete) begin
      if (!valid_q || m_ready) begin
        valid_d = 1'b1;
        data_d  = sh_cap;
      end
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end

    if (complete && valid_q && !m_ready) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      act_q    <= '0;
      miso_r_q <= '0;
      stb_p_q  <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      act_q    <= act_d;
      miso_r_q <= miso;
      stb_p_q  <= stb_p_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cfg_delay_q = act_q;
  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign overflow    = ovf_q;
  assign busy        = (cnt_q != '0) || (|stb_p_q);

  // Strobes closer than MAX_DELAY+1 clocks would overlap in the strobe pipeline.
  stb_spacing_a: assert property (@(posedge clk) disable iff (rst)
    sample_stb |-> ((stb_p_q & StbEarlyMask) == '0));

endmodule

// File: tb/tb_seeg_miso_deskew.sv
// Bench for seeg_miso_deskew: directed and randomised transfers checked by a per-edge
// reference model and a beat scoreboard popped by an independent monitor.
`timescale 1ns/1ps
module tb_seeg_miso_deskew;
  localparam int NL   = 8;
  localparam int DW   = 4;
  localparam int MD   = 7;
  localparam int WB   = 16;
  localparam int MAXC = 20000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_delay_wr;
  logic [NL*DW-1:0]  cfg_delay_data;
  logic [NL*DW-1:0]  cfg_delay_q;
  logic              frame_start;
  logic              sample_stb;
  logic [NL-1:0]     miso;
  logic              m_valid;
  logic              m_ready;
  logic [NL*WB-1:0]  m_data;
  logic              overflow;
  logic              clr_overflow;
  logic              busy;

  always #5 clk = ~clk;

  seeg_miso_deskew dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_delay_wr   (cfg_delay_wr),
    .cfg_delay_data (cfg_delay_data),
    .cfg_delay_q    (cfg_delay_q),
    .frame_start    (frame_start),
    .sample_stb     (sample_stb),
    .miso           (miso),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow),
    .busy           (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: miso history per edge, strobe edges per word, handshake occupancy.
  logic [NL-1:0]    hist [0:MAXC];
  logic [NL*DW-1:0] pend_m, act_m;
  bit               occ_m, ovf_m, have_done;
  int               cur_s[$];
  int               done_s[$];
  int               done_edge;
  int               done_dly [NL];
  logic [NL*WB-1:0] exp_q[$];
  bit               rand_ready, clr_on_drop;
  int               clr_at = -1;

  logic [WB-1:0]    wv [NL];
  int               shv [NL];

  task automatic check(input string name, input logic [NL*WB-1:0] act,
                       input logic [NL*WB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int clampd(input logic [DW-1:0] v);
    return (int'(v) > MD) ? MD : int'(v);
  endfunction

  task automatic model_reset();
    pend_m = '0; act_m = '0; occ_m = 0; ovf_m = 0; have_done = 0;
    cur_s.delete(); done_s.delete(); exp_q.delete();
  endtask

  // Applies the rules to the inputs that were sampled at edge `cyc`.
  task automatic model_edge();
    bit ready_e;
    bit set_ovf;
    logic [NL*WB-1:0] w;
    ready_e = m_ready;
    set_ovf = 0;
    hist[cyc] = miso;
    if (have_done && cyc == done_edge) begin
      w = '0;
      for (int i = 0; i < NL; i++)
        for (int b = 0; b < WB; b++)
          w[i*WB + WB-1-b] = hist[done_s[b] + done_dly[i]][i];
      if (!occ_m || ready_e) begin
        exp_q.push_back(w);
        occ_m = 1;
      end else begin
        set_ovf = 1;
      end
      have_done = 0;
    end else if (occ_m && ready_e) begin
      occ_m = 0;
    end
    ovf_m = set_ovf ? 1'b1 : (clr_overflow ? 1'b0 : ovf_m);
    if (sample_stb && !frame_start) begin
      cur_s.push_back(cyc);
      if (cur_s.size() == WB) begin
        done_s = cur_s;
        cur_s.delete();
        done_edge = cyc + MD + 1;
        have_done = 1;
        for (int i = 0; i < NL; i++) done_dly[i] = clampd(act_m[i*DW +: DW]);
        if (clr_on_drop) begin
          clr_at = done_edge;
          clr_on_drop = 0;
        end
      end
    end
    if (frame_start) begin
      cur_s.delete();
      act_m = cfg_delay_wr ? cfg_delay_data : pend_m;
    end
    if (cfg_delay_wr) pend_m = cfg_delay_data;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    sample_stb   = 1'b0;
    frame_start  = 1'b0;
    cfg_delay_wr = 1'b0;
    clr_overflow = (clr_at == cyc + 1) || (rand_ready && $urandom_range(0, 15) == 0);
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    check("m_valid", m_valid, occ_m);
    check("overflow", overflow, ovf_m);
    check("busy", busy, (cur_s.size() != 0) || have_done);
    check("cfg_delay_q", cfg_delay_q, act_m);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg(input logic [NL*DW-1:0] d, input bit fs);
    cfg_delay_wr   = 1'b1;
    cfg_delay_data = d;
    frame_start    = fs;
    tick();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
  endtask

  // Line i takes bit b of wv[i] shv[i] clocks after the strobe of bit b.
  task automatic send_bits(input int first, input int nbits, input int sp);
    for (int b = first; b < first + nbits; b++) begin
      for (int t = 0; t < sp; t++) begin
        sample_stb = (t == 0);
        for (int i = 0; i < NL; i++) if (t == shv[i]) miso[i] = wv[i][WB-1-b];
        tick();
      end
    end
  endtask

  task automatic set_all(input logic [WB-1:0] w, input int sh);
    for (int i = 0; i < NL; i++) begin
      wv[i]  = w;
      shv[i] = sh;
    end
  endtask

  task automatic set_rand(input int shmax);
    for (int i = 0; i < NL; i++) begin
      wv[i]  = WB'($urandom);
      shv[i] = $urandom_range(0, shmax);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat at cycle %0d: unexpected beat %h, none expected", cyc, m_data);
      end else begin
        check("beat_data", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_delay_wr = 0; cfg_delay_data = '0; frame_start = 0;
    sample_stb = 0; miso = '0; m_ready = 1'b1; clr_overflow = 0;
    rand_ready = 0; clr_on_drop = 0;
    model_reset();
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg", cfg_delay_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // Delay 0, single leading one on every line.
    set_all(16'h8000, 0);
    send_bits(0, WB, 10);
    idle(12);

    // Delay 2 with data moving 2 clocks after the strobe, then delay 0 on the same timing.
    cfg(32'h22222222, 0);
    start_frame();
    set_all(16'hA5C3, 2);
    send_bits(0, WB, 10);
    idle(10);
    cfg(32'h00000000, 1);
    send_bits(0, WB, 10);
    idle(10);

    // Mixed per-line delays (write coincident with frame_start), then clamped delays.
    cfg(32'h76543210, 1);
    for (int i = 0; i < NL; i++) begin
      wv[i]  = WB'(16'h1111 * i);
      shv[i] = i;
    end
    send_bits(0, WB, 9);
    idle(10);
    cfg(32'hFFFFFFFF, 1);
    set_rand(0);
    for (int i = 0; i < NL; i++) shv[i] = 7;
    send_bits(0, WB, 9);
    idle(10);

    // Back-pressure: second word dropped, clear, then clear coincident with a drop.
    cfg(32'h11111111, 1);
    m_ready = 1'b0;
    set_rand(1);
    send_bits(0, WB, 8);
    set_rand(1);
    send_bits(0, WB, 8);
    idle(10);
    check("ovf_after_drop", overflow, 1);
    m_ready = 1'b1;
    idle(2);
    clr_overflow = 1'b1;
    tick();
    check("ovf_cleared", overflow, 0);
    m_ready = 1'b0;
    set_rand(1);
    send_bits(0, WB, 8);
    clr_on_drop = 1;
    set_rand(1);
    send_bits(0, WB, 8);
    idle(10);
    check("ovf_set_wins", overflow, 1);
    m_ready = 1'b1;
    idle(2);
    clr_overflow = 1'b1;
    tick();

    // Four back-to-back words at minimum strobe spacing.
    cfg(32'h70707070, 1);
    for (int n = 0; n < 4; n++) begin
      set_rand(0);
      for (int i = 0; i < NL; i++) shv[i] = (i % 2 == 0) ? 0 : 7;
      send_bits(0, WB, 8);
    end
    idle(12);

    // Partial word dropped by frame_start; a mid-frame delay write waits for the next frame.
    set_rand(0);
    send_bits(0, 5, 10);
    idle(8);
    start_frame();
    check("busy_after_abort", busy, 0);
    set_rand(0);
    send_bits(0, 8, 10);
    cfg(32'h33333333, 0);
    send_bits(8, 8, 10);
    idle(10);
    start_frame();
    set_rand(0);
    for (int i = 0; i < NL; i++) shv[i] = 3;
    send_bits(0, WB, 10);
    idle(10);

    // Randomised delays, data timing, spacing and back-pressure.
    rand_ready = 1;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle(MD + 2);
        cfg(32'($urandom), 1);
      end
      set_rand(MD);
      send_bits(0, WB, $urandom_range(MD + 1, MD + 5));
    end
    rand_ready = 0;
    m_ready = 1'b1;
    idle(12);

    // Asynchronous reset with a held beat and a partial word in flight.
    m_ready = 1'b0;
    set_rand(0);
    send_bits(0, WB, 8);
    send_bits(0, 3, 8);
    #3;
    rst = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    check("arst_cfg", cfg_delay_q, 0);
    model_reset();
    m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_rand(0);
    send_bits(0, WB, 9);
    idle(12);
    check("beats_outstanding", 128'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/seeg_miso_deskew.md
Name: seeg_miso_deskew

Overview:
- Parametrised MISO capture stage for the SEEG front end. It generalises the fixed per-line delay setting to N_LINES lines, each with a programmable sample delay in system clocks.
- Each line is deserialised into WORD_BITS-bit words, MSB first. All lines' words for one transfer are presented as a single valid/ready beat to the stream packer.
- Sits between the SPI sequencer, which supplies the sampling strobes, and the AXI-Stream output path. The delay vector is written by the AXI-Lite register block.

Parameters:
- N_LINES, 8, number of MISO lines.
- DELAY_W, 4, bits per line in the delay field.
- MAX_DELAY, 7, largest usable delay in clocks; larger programmed values are clamped to this.
- WORD_BITS, 16, bits per converter word.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_delay_wr  in  1  one-cycle pulse; loads cfg_delay_data into the pending register.
- cfg_delay_data  in  N_LINES*DELAY_W  line i delay in bits [i*DELAY_W +: DELAY_W].
- cfg_delay_q  out  N_LINES*DELAY_W  active (shadow) delay vector, unclamped, for readback.
- frame_start  in  1  one-cycle pulse at chip-select assertion.
- sample_stb  in  1  one-cycle pulse per SCLK sampling edge.
- miso  in  N_LINES  raw MISO lines, already synchronised.
- m_valid  out  1  word beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  N_LINES*WORD_BITS  line i word in [i*WORD_BITS +: WORD_BITS].
- overflow  out  1  sticky: a completed beat was dropped.
- clr_overflow  in  1  clears overflow.
- busy  out  1  partial word in progress.

Behaviour:
- Reset values:
  - pending and active delay = 0; cfg_delay_q = 0.
  - m_valid = 0, m_data = 0, overflow = 0, busy = 0.
  - Strobe pipeline, shift registers and bit counter cleared.
- Asynchronous reset mid-frame discards the partial word and any held beat.
- Delay update:
  - cfg_delay_wr updates the pending register only.
  - Pending is copied to active on frame_start, so delays never change within a frame.
  - cfg_delay_wr coincident with frame_start: the new data goes to pending and is also applied to active that same cycle.
  - Effective delay d_i = min(active_i, MAX_DELAY).
- MISO path:
  - miso is registered once (miso_r).
  - sample_stb enters a MAX_DELAY+1 stage pipeline: stb_p[0] = sample_stb registered, and stb_p[k] is stb_p[0] delayed k clocks.
- Capture:
  - Line i shifts miso_r[i] into its WORD_BITS shift register (MSB first, left shift) on the cycle stb_p[d_i] = 1.
  - d_i = 0 means capture one clock after sample_stb.
- Word assembly:
  - The bit counter (0..WORD_BITS-1) advances on stb_p[MAX_DELAY]; by then every line has captured.
  - When the counter is WORD_BITS-1 and stb_p[MAX_DELAY] = 1, the word is complete. The counter wraps to 0 and the output logic receives the shift registers as they will be after that cycle's captures.
  - busy = (counter != 0), or any stb_p stage set.
- Constraint on sample_stb: pulses must be at least MAX_DELAY+1 clocks apart. Closer pulses are unsupported; no checking is required, but simulation asserts.
- frame_start:
  - Clears the bit counter, shift registers and strobe pipeline.
  - A partial word is dropped silently.
  - A completed word in the same cycle is still delivered.
- Output handshake (single register, AXI-Stream rules):
  - m_data is stable while m_valid && !m_ready.
  - Complete while !m_valid: load, m_valid = 1 on the next clock.
  - Complete while m_valid && m_ready: load the new word, m_valid stays 1 (back-to-back, no bubble).
  - Complete while m_valid && !m_ready: new word dropped, old beat held, overflow set next clock.
  - Beat accepted with no completion: m_valid = 0.
- Latency: the last sample_stb of a word to m_valid is MAX_DELAY+2 clocks, independent of the individual d_i.
- overflow:
  - Sticky until clr_overflow.
  - Set and clear in the same cycle: set wins.

Test Plan:
- Reset, all delays 0. Drive 16 strobes spaced 10 clocks, miso = 8'hFF for the first bit then 8'h00 -> one beat, every line 16'h8000, m_valid rising 9 clocks after the last strobe, overflow = 0.
- Write 32'h22222222, frame_start, miso transitions 2 clocks after each strobe carrying 16'hA5C3 on all lines -> all lanes 16'hA5C3. Repeat with delay 0 -> a corrupted word differing from 16'hA5C3.
- Mixed delays 32'h76543210, line i data delayed i clocks, line i pattern 16'h1111*i -> lane i = 16'h1111*i. Write 32'hFFFFFFFF -> behaves as delay 7 (clamp), cfg_delay_q reads 32'hFFFFFFFF.
- Hold m_ready = 0 across two completed words -> first word held, overflow = 1. Pulse clr_overflow -> 0. clr_overflow coincident with another drop -> overflow stays 1.
- m_ready = 1 continuously, 4 words back-to-back -> 4 beats, no gaps beyond strobe spacing, no overflow.
- frame_start after 5 bits -> partial discarded, busy = 0, next 16 bits form a clean word. cfg_delay_wr mid-frame -> takes effect only after the next frame_start.
